// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM encoding and sizing constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_e;

    localparam logic [31:0] WORD_BYTES    = 32'd4;
    localparam int          DEF_MAX_WORDS = 64;

endpackage

// File: rtl/loader_addr_cnt.sv
// loader_addr_cnt: word index counter, write-address adder and last-word compare
module loader_addr_cnt
    import prog_loader_pkg::*;
#(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [31:0]   base_i,
    input  logic [CW-1:0] cnt_i,
    output logic [31:0]   addr_o,
    output logic          last_o
);

    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;

    // next index, current byte address (wraps at 32 bits) and final-word detect
    always_comb begin
        idx_d  = clr_i ? '0 : inc_i ? idx_q + CW'(1) : idx_q;
        addr_o = base_i + 32'(idx_q) * WORD_BYTES;
        last_o = (idx_q + CW'(1)) == cnt_i;
    end

    // index register, cleared by reset and by every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, then releases the core from reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS   = DEF_MAX_WORDS,
    parameter int RELEASE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [31:0]                load_base,
    input  logic [$clog2(MAX_WORDS):0] word_cnt,
    input  logic                       src_valid,
    input  logic [31:0]                src_data,
    output logic                       src_ready,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       core_rst_n,
    output logic [31:0]                start_pc,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int HW = $clog2(RELEASE_CYC + 2);

    state_e        state_q;
    logic          src_ready_q;
    logic          imem_we_q;
    logic [31:0]   imem_addr_q;
    logic [31:0]   imem_wdata_q;
    logic          core_rst_n_q;
    logic [31:0]   start_pc_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hold_q;

    logic          start_ok;
    logic          start_acc;
    logic          take;
    logic [31:0]   wr_addr;
    logic          last_word;

    // start legality, accepted start and accepted source word
    always_comb begin
        start_ok  = (load_base[1:0] == 2'b00) && (word_cnt <= CW'(MAX_WORDS));
        start_acc = start && start_ok && ((state_q == S_IDLE) || (state_q == S_ERR));
        take      = (state_q == S_LOAD) && src_valid;
    end

    loader_addr_cnt #(
        .CW (CW)
    ) u_addr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc),
        .inc_i  (take),
        .base_i (start_pc_q),
        .cnt_i  (cnt_q),
        .addr_o (wr_addr),
        .last_o (last_word)
    );

    // loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_ready_q  <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            start_pc_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
            hold_q       <= '0;
        end else begin
            imem_we_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start && !start_ok) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else if (start_acc) begin
                        error_q    <= 1'b0;
                        start_pc_q <= load_base;
                        cnt_q      <= word_cnt;
                        busy_q     <= 1'b1;
                        if (word_cnt == '0) begin
                            // no write to wait for: the start cycle stands in for the last write
                            state_q <= S_HOLD;
                            hold_q  <= HW'(1);
                        end else begin
                            state_q     <= S_LOAD;
                            src_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= wr_addr;
                        imem_wdata_q <= src_data;
                        if (last_word) begin
                            state_q     <= S_HOLD;
                            src_ready_q <= 1'b0;
                            hold_q      <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q >= HW'(RELEASE_CYC)) begin
                        state_q      <= S_RUN;
                        busy_q       <= 1'b0;
                        core_rst_n_q <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // drive ports straight from the registers
    always_comb begin
        src_ready  = src_ready_q;
        imem_we    = imem_we_q;
        imem_addr  = imem_addr_q;
        imem_wdata = imem_wdata_q;
        core_rst_n = core_rst_n_q;
        start_pc   = start_pc_q;
        busy       = busy_q;
        done       = done_q;
        error      = error_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench against a word-stream reference model
module tb_prog_loader;

    localparam int MAXW = 64;
    localparam int RC   = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic [31:0] load_base = '0;
    logic [6:0]  word_cnt  = '0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data  = '0;
    logic        src_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic [31:0] start_pc;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    bit          m_ready  = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_addr   = '0;
    int          first_wr = -1;
    int          last_wr  = 0;

    prog_loader #(
        .MAX_WORDS   (MAXW),
        .RELEASE_CYC (RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_base  (load_base),
        .word_cnt   (word_cnt),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .start_pc   (start_pc),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc_n);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // one clock: handshake expectation before the edge, write expectation after it
    task automatic step();
        logic        acc;
        logic [31:0] d;
        check("src_ready", src_ready, m_ready);
        acc = src_valid && m_ready;
        d   = src_data;
        @(posedge clk);
        #1;
        cyc_n++;
        check("imem_we", imem_we, acc);
        if (acc) begin
            check("imem_addr", imem_addr, m_addr);
            check("imem_wdata", imem_wdata, d);
            if (first_wr < 0) first_wr = cyc_n;
            last_wr = cyc_n;
            m_addr  = m_addr + 32'd4;
            m_left--;
            if (m_left == 0) m_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        m_left  = 0;
        #1;
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_start_pc", start_pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        start     = 1'b0;
        src_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc_n++;
        rst_n = 1'b1;
    endtask

    task automatic run_load(input logic [31:0] base, input int n, input int vpct, input int gap_at,
                            input int gap_len, input bit seq, input bit noise, input int abort_at);
        int start_c;
        int guard;
        int gap_c;
        int got;
        int t_ref;
        load_base = base;
        word_cnt  = 7'(n);
        start     = 1'b1;
        start_c   = cyc_n;
        step();
        start    = 1'b0;
        m_ready  = (n > 0);
        m_left   = n;
        m_addr   = base;
        first_wr = -1;
        check("start_pc_capt", start_pc, base);
        check("busy_after_start", busy, 1);
        check("error_after_start", error, 0);
        guard = 0;
        gap_c = 0;
        while (m_left > 0 && guard < 4000) begin
            got = n - m_left;
            if (got == abort_at) begin
                do_reset();
                src_valid = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    src_data = $urandom;
                    step();
                end
                src_valid = 1'b0;
                check("abort_start_pc", start_pc, 0);
                check("abort_busy", busy, 0);
                check("abort_core_rst_n", core_rst_n, 0);
                return;
            end
            if (got == gap_at && gap_c < gap_len) begin
                src_valid = 1'b0;
                gap_c++;
            end else begin
                src_valid = ($urandom_range(99) < vpct);
            end
            src_data = seq ? 32'hA + 32'(got) : $urandom;
            if (noise && $urandom_range(3) == 0) begin
                start     = 1'b1;
                load_base = $urandom;
                word_cnt  = 7'($urandom_range(MAXW));
            end else begin
                start = 1'b0;
            end
            step();
            guard++;
        end
        check("load_complete", m_left, 0);
        if (n > 0 && vpct == 100 && gap_len == 0) check("b2b_span", last_wr - first_wr, n - 1);
        src_valid = 1'b1;
        src_data  = $urandom;
        start     = noise;
        load_base = 32'h40;
        word_cnt  = 7'd1;
        t_ref     = (n == 0) ? start_c : last_wr;
        guard     = 0;
        while (!done && guard < 20) begin
            check("hold_core_rst_n", core_rst_n, 0);
            check("hold_busy", busy, 1);
            step();
            start = 1'b0;
            guard++;
        end
        check("done_cycle", cyc_n, t_ref + RC + 1);
        check("run_core_rst_n", core_rst_n, 1);
        check("run_busy", busy, 0);
        check("run_start_pc", start_pc, base);
        check("run_error", error, 0);
        step();
        check("done_one_cycle", done, 0);
        check("run_core_stays", core_rst_n, 1);
        start     = 1'b1;
        load_base = 32'h0;
        word_cnt  = 7'd1;
        step();
        start = 1'b0;
        step();
        step();
        src_valid = 1'b0;
        check("run_ignores_start_busy", busy, 0);
        check("run_ignores_start_core", core_rst_n, 1);
        check("run_ignores_start_pc", start_pc, base);
    endtask

    initial begin
        #1;
        do_reset();
        step();
        check("idle_busy", busy, 0);
        check("idle_core_rst_n", core_rst_n, 0);

        run_load(32'h74, 3, 100, -1, 0, 1'b1, 1'b0, -1);
        do_reset();
        run_load(32'h74, 3, 100, 1, 2, 1'b1, 1'b0, -1);

        do_reset();
        load_base = 32'h76;
        word_cnt  = 7'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("err_set", error, 1);
        check("err_busy", busy, 0);
        check("err_core_rst_n", core_rst_n, 0);
        src_valid = 1'b1;
        step();
        step();
        src_valid = 1'b0;
        load_base = 32'h0;
        word_cnt  = 7'(MAXW + 1);
        start     = 1'b1;
        step();
        start = 1'b0;
        check("err_too_long", error, 1);
        run_load(32'h0, 1, 100, -1, 0, 1'b0, 1'b0, -1);

        do_reset();
        run_load(32'h100, 0, 100, -1, 0, 1'b0, 1'b0, -1);
        do_reset();
        run_load(32'hFFFF_FFF8, 3, 100, -1, 0, 1'b0, 1'b0, -1);
        do_reset();
        run_load(32'h1000, MAXW, 100, -1, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            run_load($urandom & 32'hFFFF_FFFC, $urandom_range(1, 10), $urandom_range(40, 100),
                     $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, 1'b1, -1);
        end

        do_reset();
        run_load(32'h200, 4, 100, -1, 0, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
